// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// service FSM states and the default source count.
package irq_pkg;

  localparam int unsigned NUM_SRC_DEFAULT = 8;

  localparam logic [3:0] ADDR_ENABLE  = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h4;
  localparam logic [3:0] ADDR_MODE    = 4'h8;
  localparam logic [3:0] ADDR_CLAIM   = 4'hC;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

endpackage

// File: rtl/irq_sync.sv
// One interrupt line: 2-flop synchronizer, a registered level tap and a
// registered rising-edge pulse.
module irq_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  output logic level_o,
  output logic rise_o
);

  logic       s1_q, s2_q, s3_q;
  logic       rise_q, rise_d;
  logic [2:0] arm_q, arm_d;

  // arm_q[2] marks s3_q as holding a real post-reset sample, so a line held
  // high across reset release is not mistaken for an edge.
  always_comb begin
    arm_d  = {arm_q[1:0], 1'b1};
    rise_d = s2_q & ~s3_q & arm_q[2];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      s1_q   <= src_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= rise_d;
      arm_q  <= arm_d;
    end
  end

  assign level_o = s3_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source enable/mode/pending registers, fixed
// lowest-index-first priority, and a claim/complete service handshake.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [3:0]         addr_i,
  input  logic [31:0]        wdata_i,
  input  logic               we_i,
  input  logic               re_i,
  output logic [31:0]        rdata_o,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] level, rise;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .src_i  (src_i[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  state_e             state_q, state_d;
  logic [4:0]         claimed_id_q, claimed_id_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0] active, win_oh, clr;
  logic [4:0]         win_idx;
  logic               found, rd_en, claim_ok;
  logic               unused_wdata;

  assign unused_wdata = ^wdata_i;
  assign active       = pending_q & enable_q;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!found && active[i]) begin
        found     = 1'b1;
        win_idx   = 5'(i);
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    enable_d     = enable_q;
    mode_d       = mode_q;
    state_d      = state_q;
    claimed_id_d = claimed_id_q;
    rdata_d      = rdata_q;
    clr          = '0;
    // A simultaneous write masks the read completely, including claim side effects.
    rd_en        = re_i & ~we_i;
    claim_ok     = rd_en && (addr_i == ADDR_CLAIM) && (state_q == IDLE) && found;

    if (we_i) begin
      unique case (addr_i)
        ADDR_ENABLE:  enable_d = wdata_i[NUM_SRC-1:0];
        ADDR_MODE:    mode_d   = wdata_i[NUM_SRC-1:0];
        ADDR_PENDING: clr      = wdata_i[NUM_SRC-1:0];
        ADDR_CLAIM: begin
          if ((state_q == SERVICE) && (wdata_i[4:0] == claimed_id_q + 5'd1)) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    if (claim_ok) begin
      state_d      = SERVICE;
      claimed_id_d = win_idx;
      clr          = clr | win_oh;
    end

    if (rd_en) begin
      rdata_d = '0;
      unique case (addr_i)
        ADDR_ENABLE:  rdata_d[NUM_SRC-1:0] = enable_q;
        ADDR_PENDING: rdata_d[NUM_SRC-1:0] = pending_q;
        ADDR_MODE:    rdata_d[NUM_SRC-1:0] = mode_q;
        ADDR_CLAIM:   if (claim_ok) rdata_d[4:0] = win_idx + 5'd1;
        default: ;
      endcase
    end

    // Edge sources: a same-cycle rise beats any clear. Level sources follow the line.
    pending_d = (mode_q & (rise | (pending_q & ~clr))) | (~mode_q & level);
    irq_d     = (state_q == IDLE) && (|active);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q     <= '0;
      mode_q       <= '0;
      pending_q    <= '0;
      state_q      <= IDLE;
      claimed_id_q <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      claimed_id_q <= claimed_id_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table, directed corner sequences
// and a random run, all against a cycle-level reference model.
module tb_irq_ctrl;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  src = '0;
  logic [3:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic          we = 1'b0, re = 1'b0;
  logic [31:0]   rdata;
  logic          irq;

  irq_ctrl #(.NUM_SRC(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .src_i  (src),
    .addr_i (addr),
    .wdata_i(wdata),
    .we_i   (we),
    .re_i   (re),
    .rdata_o(rdata),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: h[j] is src as sampled j edges ago, hv[j] says that
  // sample was taken after reset release.
  logic [N-1:0] h [1:4];
  logic         hv[1:4];
  logic [N-1:0] m_en, m_mode, m_pend;
  logic         m_busy, m_irq;
  int           m_cid;
  logic [31:0]  m_rdata;
  logic [N-1:0] cur_src;

  typedef struct {
    logic        w;
    logic        r;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } row_t;
  row_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 1; j <= 4; j++) begin
      h[j]  = '0;
      hv[j] = 1'b0;
    end
    m_en = '0; m_mode = '0; m_pend = '0;
    m_busy = 1'b0; m_irq = 1'b0; m_cid = 0; m_rdata = '0;
  endtask

  // One clock: drive inputs, step the model from pre-edge state, compare after the edge.
  task automatic cyc(input logic w, input logic r, input logic [3:0] a,
                     input logic [31:0] d, input logic [N-1:0] s);
    logic [N-1:0] act, clr, nx_en, nx_mode, nx_pend;
    logic         nx_busy, nx_irq;
    int           nx_cid, win;
    logic [31:0]  nx_rd;
    we = w; re = r; addr = a; wdata = d; src = s;

    act = m_pend & m_en;
    nx_en = m_en; nx_mode = m_mode; nx_busy = m_busy; nx_cid = m_cid; nx_rd = m_rdata;
    clr = '0;
    if (w) begin
      if (a == 4'h0) nx_en = d[N-1:0];
      else if (a == 4'h8) nx_mode = d[N-1:0];
      else if (a == 4'h4) clr = d[N-1:0];
      else if (a == 4'hC && m_busy && int'(d[4:0]) == m_cid + 1) nx_busy = 1'b0;
    end else if (r) begin
      nx_rd = 0;
      if (a == 4'h0) nx_rd = 32'(m_en);
      else if (a == 4'h4) nx_rd = 32'(m_pend);
      else if (a == 4'h8) nx_rd = 32'(m_mode);
      else if (a == 4'hC && !m_busy && act != 0) begin
        win = 0;
        while (!act[win]) win++;
        nx_rd = 32'(win + 1);
        nx_cid = win;
        nx_busy = 1'b1;
        clr[win] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_mode[i])
        nx_pend[i] = (h[3][i] && !h[4][i] && hv[4]) || (m_pend[i] && !clr[i]);
      else
        nx_pend[i] = h[3][i];
    end
    nx_irq = !m_busy && act != 0;

    @(posedge clk);
    #1;
    for (int j = 4; j > 1; j--) begin
      h[j]  = h[j-1];
      hv[j] = hv[j-1];
    end
    h[1] = s; hv[1] = 1'b1;
    m_en = nx_en; m_mode = nx_mode; m_pend = nx_pend; m_busy = nx_busy;
    m_cid = nx_cid; m_rdata = nx_rd; m_irq = nx_irq;
    check("model_irq", {31'b0, irq}, {31'b0, m_irq});
    check("model_rdata", rdata, m_rdata);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d, cur_src);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(1'b0, 1'b1, a, 32'h0, cur_src);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, cur_src);
  endtask

  task automatic do_reset(input logic chk_async);
    rst_n = 1'b0; we = 1'b0; re = 1'b0; src = '1;
    #2;
    if (chk_async) begin
      check("async_rst_rdata", rdata, 32'h0);
      check("async_rst_irq", {31'b0, irq}, 32'h0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    src = '0; cur_src = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    cur_src = '0;
    model_reset();

    // Reset and register table
    do_reset(1'b0);
    rd(4'h4);
    check("rst_pending", rdata, 32'h0);
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 4'h0, 32'h0,         32'hFF};
    tbl[2]  = '{1'b0, 1'b1, 4'h2, 32'h0,         32'h0};
    tbl[3]  = '{1'b1, 1'b0, 4'h8, 32'h0000_01A5, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'hA5};
    tbl[5]  = '{1'b0, 1'b1, 4'hE, 32'h0,         32'h0};
    tbl[6]  = '{1'b0, 1'b1, 4'hC, 32'h0,         32'h0};
    tbl[7]  = '{1'b0, 1'b1, 4'h4, 32'h0,         32'h0};
    tbl[8]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'hA5};
    tbl[9]  = '{1'b1, 1'b1, 4'h0, 32'h0000_000F, 32'hA5};
    tbl[10] = '{1'b0, 1'b1, 4'h0, 32'h0,         32'h0F};
    tbl[11] = '{1'b1, 1'b0, 4'h8, 32'h0,         32'h0F};
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, cur_src);
      check($sformatf("tbl%0d", i), rdata, tbl[i].exp);
    end

    // Edge source latency and claim
    do_reset(1'b1);
    wr(4'h8, 32'h1);
    wr(4'h0, 32'h1);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 8'h01);
    idle(3);
    check("edge_irq_k3", {31'b0, irq}, 32'h0);
    idle(1);
    check("edge_irq_k4", {31'b0, irq}, 32'h1);
    rd(4'hC);
    check("edge_claim", rdata, 32'h1);
    idle(1);
    check("edge_irq_drop", {31'b0, irq}, 32'h0);
    rd(4'h4);
    check("edge_pend_clr", rdata, 32'h0);
    wr(4'hC, 32'h1);

    // Priority and wrong completion
    do_reset(1'b1);
    wr(4'h8, 32'h28);
    wr(4'h0, 32'h28);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 8'h28);
    idle(4);
    rd(4'hC);
    check("prio_claim3", rdata, 32'h4);
    wr(4'hC, 32'h2);
    idle(1);
    check("wrong_irq", {31'b0, irq}, 32'h0);
    rd(4'hC);
    check("wrong_claim_busy", rdata, 32'h0);
    wr(4'h0, 32'h20);
    wr(4'hC, 32'h4);
    idle(1);
    check("prio_reassert", {31'b0, irq}, 32'h1);
    rd(4'hC);
    check("prio_claim5", rdata, 32'h6);
    wr(4'hC, 32'h6);

    // Level source
    do_reset(1'b1);
    wr(4'h0, 32'h4);
    cur_src = 8'h04;
    idle(5);
    check("lvl_irq", {31'b0, irq}, 32'h1);
    rd(4'hC);
    check("lvl_claim", rdata, 32'h3);
    wr(4'hC, 32'h3);
    idle(1);
    check("lvl_reassert", {31'b0, irq}, 32'h1);
    cur_src = '0;
    idle(4);
    rd(4'h4);
    check("lvl_pend_clr", rdata, 32'h0);

    // Edge-set versus W1C in the same cycle
    do_reset(1'b1);
    wr(4'h8, 32'h1);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 8'h01);
    idle(2);
    wr(4'h4, 32'h1);
    rd(4'h4);
    check("collision_set_wins", rdata, 32'h1);
    wr(4'h4, 32'h1);
    rd(4'h4);
    check("w1c_clears", rdata, 32'h0);

    // Reset while in service drops the claim
    wr(4'h0, 32'h1);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 8'h01);
    idle(4);
    rd(4'hC);
    check("svc_claim", rdata, 32'h1);
    do_reset(1'b1);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic        w, r;
      logic [3:0]  a;
      logic [31:0] d;
      if ($urandom_range(0, 7) == 0) cur_src = cur_src ^ N'($urandom);
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: a = 4'h0;
        1: a = 4'h4;
        2: a = 4'h8;
        3: a = 4'hC;
        default: a = 4'($urandom);
      endcase
      d = $urandom;
      if (a == 4'hC && $urandom_range(0, 1) == 1) d = 32'(m_cid + 1);
      cyc(w, r, a, d, cur_src);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
